ctrl_if_fifo: RTL



---
 rtl/ctrl_if_fifo_pkg.sv | 10 +
 rtl/ctrl_if_fifo_if.sv | 41 ++++
 rtl/ctrl_if_fifo_sync_fifo_sa.sv | 68 ++++++
 rtl/ctrl_if_fifo.sv | 82 ++++++++
 4 files changed

// File: rtl/ctrl_if_fifo_pkg.sv
// rtl/ctrl_if_fifo_pkg.sv - shared widths and lane-index type for the control ingress FIFO
// Package ctrl_fifo_pkg: WORD_W (FIFO word), BYTE_W (host byte), LANES (bytes per word), lane_t.
// Optional build macro used by the bundle: CTRL_IF_FIFO_USEDW_EN.
package ctrl_fifo_pkg;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LANES  = WORD_W / BYTE_W;

    typedef logic [1:0] lane_t;
endpackage

// File: rtl/ctrl_if_fifo_if.sv
// rtl/ctrl_if_fifo_if.sv - host byte / CPU word bus bundle for ctrl_if_fifo
// master: host + control CPU side (drives host_d/host_wr/host_last/fifo_rst/if_rd).
// slave : ctrl_if_fifo (drives host_full/if_d/if_rdempty/ovf and, with
//         CTRL_IF_FIFO_USEDW_EN defined, usedw).
interface ctrl_if_fifo_if
    import ctrl_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
);
    logic [BYTE_W-1:0] host_d;
    logic              host_wr;
    logic              host_last;
    logic              host_full;
    logic              fifo_rst;
    logic              if_rd;
    logic [WORD_W-1:0] if_d;
    logic              if_rdempty;
    logic              ovf;
`ifdef CTRL_IF_FIFO_USEDW_EN
    logic [AW:0]       usedw;

    modport master (
        output host_d, host_wr, host_last, fifo_rst, if_rd,
        input  host_full, if_d, if_rdempty, ovf, usedw
    );
    modport slave (
        input  host_d, host_wr, host_last, fifo_rst, if_rd,
        output host_full, if_d, if_rdempty, ovf, usedw
    );
`else
    modport master (
        output host_d, host_wr, host_last, fifo_rst, if_rd,
        input  host_full, if_d, if_rdempty, ovf
    );
    modport slave (
        input  host_d, host_wr, host_last, fifo_rst, if_rd,
        output host_full, if_d, if_rdempty, ovf
    );
`endif
endinterface

// File: rtl/ctrl_if_fifo_sync_fifo_sa.sv
// rtl/ctrl_if_fifo_sync_fifo_sa.sv - generic single-clock show-ahead FIFO with flush
// Ports: clk, reset (sync, active-high), flush (sync clear), push/push_data,
//        pop, rd_data (head word, combinational from mem[rd_ptr]), empty, full, count.
// empty/full are registered from the next count; push is ignored while full,
// pop is ignored while empty.
module sync_fifo_sa #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] ZERO_C  = '0;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic          push_ok;
    logic          pop_ok;

    // Qualify against registered flags so no handshake input reaches a flag combinationally.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + ONE_C;
            2'b01:   count_nxt = count - ONE_C;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == ZERO_C);
            full  <= (count_nxt == DEPTH_C);
        end
    end

    // Storage carries no reset; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !reset && !flush) mem[wr_ptr] <= push_data;
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/ctrl_if_fifo.sv
// rtl/ctrl_if_fifo.sv - host control byte packer feeding a show-ahead word FIFO for the control CPU
// Ports: clk, reset (sync, active-high), bus (ctrl_if_fifo_if.slave):
//   host_d/host_wr/host_last -> byte input, host_full back-pressure,
//   fifo_rst CPU flush, if_rd pop, if_d head word, if_rdempty, ovf sticky drop flag,
//   usedw word count (only when CTRL_IF_FIFO_USEDW_EN is defined).
module ctrl_if_fifo
    import ctrl_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_if_fifo_if.slave  bus
);
    lane_t             bcnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_nxt;
    logic              accept;
    logic              push;
    logic              full;
    logic              empty;
    logic [AW:0]       count;
    logic              ovf_r;

    // fifo_rst wins over a byte in the same cycle: it is discarded, not counted as a drop.
    assign accept = bus.host_wr && !full && !bus.fifo_rst;
    assign push   = accept && ((bcnt == lane_t'(LANES-1)) || bus.host_last);

    // shreg is cleared after every push, so lanes above bcnt are already zero.
    always_comb begin
        word_nxt = shreg;
        word_nxt[BYTE_W*bcnt +: BYTE_W] = bus.host_d;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.fifo_rst) begin
            bcnt  <= '0;
            shreg <= '0;
        end else if (accept) begin
            if (push) begin
                bcnt  <= '0;
                shreg <= '0;
            end else begin
                bcnt  <= bcnt + lane_t'(1);
                shreg <= word_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.fifo_rst) ovf_r <= 1'b0;
        else if (bus.host_wr && full) ovf_r <= 1'b1;
    end

    sync_fifo_sa #(
        .DW    (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.fifo_rst),
        .push      (push),
        .push_data (word_nxt),
        .pop       (bus.if_rd),
        .rd_data   (bus.if_d),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    assign bus.host_full  = full;
    assign bus.if_rdempty = empty;
    assign bus.ovf        = ovf_r;

`ifdef CTRL_IF_FIFO_USEDW_EN
    assign bus.usedw = count;
`else
    logic unused_count;
    assign unused_count = ^count;
`endif
endmodule
